mem_bus_arbiter: RTL and testbench

- Shares one single-port instruction/data memory bus between the fetch stage (driven by the PC) and the MEM stage.
- Sequences each access as a request/acknowledge transaction with variable memory latency.
- Raises per-stage stall requests to the pipeline stall controller while an access is outstanding.
- Handles fetch flush on taken branches and provides a watchdog timeout.

---
 rtl/mem_bus_arbiter_pkg.sv | 26 ++
 rtl/mem_bus_arbiter_bus_watchdog.sv | 47 ++++
 rtl/mem_bus_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_pkg
//   Shared definitions for the instruction/data memory bus arbiter:
//   FSM state encoding, reset level, fetch byte-enable pattern, and the
//   watchdog width and default timeout.
// -----------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

  // Arbiter FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_IF_BUSY  = 2'd1,
    ARB_MEM_BUSY = 2'd2
  } arb_state_e;

  // Level of rst that holds the block in reset.
  localparam logic RSTN_ENABLE = 1'b0;

  // Fetches always read a full word.
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // Watchdog counter width; the timeout must fit in it and be at least 1.
  localparam int WDOG_W          = 8;
  localparam int TIMEOUT_DEFAULT = 255;

endpackage : mem_bus_arbiter_pkg

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_bus_watchdog
//   Saturating busy-cycle counter for the arbiter. Counts cycles while en=1,
//   returns to zero on clr, and flags terminal count when the current busy
//   cycle is the TIMEOUT_CYC-th one without completion.
//
// Ports
//   clk  in   system clock, rising edge
//   rst  in   asynchronous reset, active-low
//   clr  in   synchronous clear (priority over en)
//   en   in   count this cycle
//   tc   out  terminal count reached in the current busy cycle
// -----------------------------------------------------------------------------
module mem_bus_arbiter_bus_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // The count holds the number of busy cycles already elapsed, so the
  // TIMEOUT_CYC-th busy cycle is the one that sees TIMEOUT_CYC-1.
  localparam logic [WDOG_W-1:0] TC_VAL  = WDOG_W'(TIMEOUT_CYC - 1);
  localparam logic [WDOG_W-1:0] CNT_MAX = '1;

  logic [WDOG_W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + 1'b1;   // saturates, never wraps
    end
  end

  assign tc = en && (count >= TC_VAL);

endmodule : mem_bus_arbiter_bus_watchdog

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one single-port memory bus between the fetch stage and the MEM
//   stage. Each access is a registered request/acknowledge transaction with
//   variable memory latency. MEM has fixed priority. A taken-branch flush
//   discards an in-flight fetch; a watchdog aborts a transaction that never
//   receives bus_ack and raises a sticky bus_err.
//
// Ports
//   clk, rst                  clock (rising) / async active-low reset
//   if_req, if_addr           fetch request and PC, held until if_ack
//   if_ack, if_rdata          fetch completion pulse and instruction
//   flush                     branch taken: drop in-flight/pending fetch
//   mem_req/we/addr/wdata/sel data request and qualifiers, held until mem_ack
//   mem_ack, mem_rdata        data completion pulse and load data
//   stall_req_if/mem          per-stage stall requests (combinational)
//   bus_req/we/addr/wdata/sel registered memory bus command
//   bus_ack, bus_rdata        memory completion and read data
//   bus_err, err_clr          sticky timeout flag and its clear
// -----------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  // fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              flush,
  // data requester
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [3:0]        mem_sel,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  // stall controller
  output logic              stall_req_if,
  output logic              stall_req_mem,
  // memory bus
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_sel,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  // error reporting
  output logic              bus_err,
  input  logic              err_clr
);

  arb_state_e state, state_nxt;

  logic discard, discard_d;
  logic busy, done, tmo, wd_tc, wd_clr;
  logic mem_cand, if_cand, if_drop;

  // Next values of the registered outputs.
  logic              bus_req_d, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_d;
  logic [3:0]        bus_sel_d;
  logic              if_ack_d, mem_ack_d, bus_err_d;
  logic [DATA_W-1:0] if_rdata_d, mem_rdata_d;

  assign stall_req_if  = if_req  & ~if_ack;
  assign stall_req_mem = mem_req & ~mem_ack;

  // A requester whose ack is showing this cycle still holds its request;
  // masking it here stops the finished access from being issued twice.
  assign mem_cand = mem_req & ~mem_ack;
  assign if_cand  = if_req  & ~if_ack & ~flush;

  assign busy = (state != ARB_IDLE);
  assign done = busy & bus_ack;            // completion beats the watchdog
  assign tmo  = busy & ~bus_ack & wd_tc;

  // A fetch is stale if a branch was taken at any point while it was on the
  // bus, including the cycle its data (or its timeout) arrives.
  assign if_drop = discard | flush;

  assign wd_clr = ~busy | done | tmo;

  mem_bus_arbiter_bus_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk (clk),
    .rst (rst),
    .clr (wd_clr),
    .en  (busy),
    .tc  (wd_tc)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default first;
  // a path that leaves it unassigned would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE: begin
        if (mem_cand)     state_nxt = ARB_MEM_BUSY;
        else if (if_cand) state_nxt = ARB_IF_BUSY;
      end
      ARB_IF_BUSY, ARB_MEM_BUSY: begin
        if (done || tmo)  state_nxt = ARB_IDLE;
      end
      default:            state_nxt = ARB_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: next value of every registered output
  // ---------------------------------------------------------------------------
  always_comb begin
    bus_req_d   = bus_req;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    bus_sel_d   = bus_sel;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata;
    mem_rdata_d = mem_rdata;
    discard_d   = discard;

    unique case (state)
      ARB_IDLE: begin
        discard_d = 1'b0;
        if (mem_cand) begin
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          bus_sel_d   = mem_sel;
        end else if (if_cand) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = '0;
          bus_sel_d   = SEL_WORD;
        end
      end

      ARB_IF_BUSY: begin
        if (flush) discard_d = 1'b1;
        if (done || tmo) begin
          bus_req_d = 1'b0;
          discard_d = 1'b0;
          if (!if_drop) begin
            if_ack_d   = 1'b1;
            if_rdata_d = done ? bus_rdata : '0;
          end
        end
      end

      ARB_MEM_BUSY: begin
        if (done || tmo) begin
          bus_req_d   = 1'b0;
          mem_ack_d   = 1'b1;
          mem_rdata_d = done ? bus_rdata : '0;
        end
      end

      default: begin
        bus_req_d = 1'b0;
        discard_d = 1'b0;
      end
    endcase

    // Sticky error: a new timeout wins over a simultaneous clear.
    if (tmo)          bus_err_d = 1'b1;
    else if (err_clr) bus_err_d = 1'b0;
    else              bus_err_d = bus_err;
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RSTN_ENABLE) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_sel   <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
      discard   <= 1'b0;
    end else begin
      bus_req   <= bus_req_d;
      bus_we    <= bus_we_d;
      bus_addr  <= bus_addr_d;
      bus_wdata <= bus_wdata_d;
      bus_sel   <= bus_sel_d;
      if_ack    <= if_ack_d;
      mem_ack   <= mem_ack_d;
      if_rdata  <= if_rdata_d;
      mem_rdata <= mem_rdata_d;
      bus_err   <= bus_err_d;
      discard   <= discard_d;
    end
  end

endmodule : mem_bus_arbiter

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Randomised fetch and data requesters share the arbiter while a memory
//   responder answers with random latency (or never, to force timeouts) and
//   sprinkles stray bus_ack pulses while the bus is idle. A negedge monitor
//   predicts bus ownership from the arbitration rules, checks the bus command,
//   queues the expected acknowledge for each completed or aborted transaction,
//   and compares it when an ack appears. A final phase resets the block in the
//   middle of a data access and checks that a pending fetch is served after.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0, mem_we = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_sel = '0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_req_if, stall_req_mem;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err;
  logic        err_clr = 1'b0;

  int  total = 0;
  int  bad   = 0;
  bit  mon_en = 1'b0;
  bit  no_ack_mode = 1'b0;

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_req_if(stall_req_if), .stall_req_mem(stall_req_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory responder: picks a latency per transaction (0 = never answer).
  // ---------------------------------------------------------------------------
  initial begin
    int cnt;
    int ack_at;
    cnt = 0;
    ack_at = 0;
    forever begin
      @(posedge clk); #1;
      err_clr   = ($urandom_range(0, 9) == 0);
      bus_rdata = $urandom;
      if (bus_req) begin
        if (cnt == 0) begin
          if (no_ack_mode || $urandom_range(0, 4) == 0) ack_at = 0;
          else ack_at = $urandom_range(1, TMO);
        end
        cnt++;
        bus_ack = (cnt == ack_at);
      end else begin
        cnt = 0;
        bus_ack = !no_ack_mode && ($urandom_range(0, 7) == 0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard (samples on the falling edge).
  // ---------------------------------------------------------------------------
  initial begin
    bit          m_busy, m_is_mem, m_end, m_discard, m_err, tmo;
    int          m_len, cyc;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_sel;
    bit          p_mem_cand, p_if_cand;
    logic        p_we;
    logic [31:0] p_maddr, p_wdata, p_iaddr;
    logic [3:0]  p_sel;
    exp_t        e;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!mon_en) begin
        m_busy = 0; m_end = 0; m_discard = 0; m_err = 0; m_len = 0; m_is_mem = 0;
        m_we = 0; m_addr = '0; m_wdata = '0; m_sel = '0;
        p_mem_cand = 0; p_if_cand = 0; p_we = 0;
        p_maddr = '0; p_wdata = '0; p_iaddr = '0; p_sel = '0;
        exp_q.delete();
        continue;
      end

      // Acknowledge pulses against the queued expectations.
      if (if_ack || mem_ack) begin
        if (exp_q.size() == 0) begin
          check("ack_unexpected", {62'd0, if_ack, mem_ack}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_owner", {62'd0, if_ack, mem_ack}, e.is_mem ? 64'd1 : 64'd2);
          check("ack_cycle", 64'(cyc), 64'(e.due));
          check("ack_rdata", e.is_mem ? mem_rdata : if_rdata, e.data);
        end
      end
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check("ack_missing", {63'd0, if_ack | mem_ack}, 64'd1);
        void'(exp_q.pop_front());
      end

      check("stall_if",  stall_req_if,  if_req  & ~if_ack);
      check("stall_mem", stall_req_mem, mem_req & ~mem_ack);
      check("bus_err",   bus_err,       m_err);

      // Who should own the bus this cycle.
      if (m_busy && m_end) begin
        m_busy = 0;
      end else if (!m_busy && (p_mem_cand || p_if_cand)) begin
        m_busy    = 1;
        m_is_mem  = p_mem_cand;
        m_len     = 0;
        m_discard = 0;
        m_we      = p_mem_cand ? p_we    : 1'b0;
        m_addr    = p_mem_cand ? p_maddr : p_iaddr;
        m_wdata   = p_wdata;
        m_sel     = p_mem_cand ? p_sel   : 4'hF;
      end
      m_end = 0;
      tmo   = 0;

      check("bus_req", bus_req, m_busy);
      if (m_busy) begin
        check("bus_addr", bus_addr, m_addr);
        check("bus_we",   bus_we,   m_we);
        check("bus_sel",  bus_sel,  m_sel);
        if (m_is_mem) check("bus_wdata", bus_wdata, m_wdata);
        m_len++;
        if (!m_is_mem && flush) m_discard = 1;
        if (bus_ack) begin
          m_end = 1;
          if (m_is_mem || !m_discard)
            exp_q.push_back('{is_mem: m_is_mem, data: bus_rdata, due: cyc + 1});
        end else if (m_len == TMO) begin
          m_end = 1;
          tmo   = 1;
          if (m_is_mem || !m_discard)
            exp_q.push_back('{is_mem: m_is_mem, data: 32'd0, due: cyc + 1});
        end
      end

      if (tmo) m_err = 1;
      else if (err_clr) m_err = 0;

      // Requests visible to the arbiter at the coming edge.
      p_mem_cand = !m_busy && mem_req && !mem_ack;
      p_if_cand  = !m_busy && if_req && !if_ack && !flush;
      p_we = mem_we; p_maddr = mem_addr; p_wdata = mem_wdata; p_sel = mem_sel;
      p_iaddr = if_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Requesters
  // ---------------------------------------------------------------------------
  task automatic run_fetch(input int n);
    for (int i = 0; i < n; i++) begin
      bit got;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      if_req  = 1'b1;
      if_addr = 32'($urandom_range(0, 1023)) << 2;
      got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(posedge clk); #1;
        flush = 1'b0;
        if (if_ack) got = 1;
        else if ($urandom_range(0, 11) == 0) begin
          flush   = 1'b1;
          if_addr = 32'($urandom_range(0, 1023)) << 2;
        end
      end
      check("fetch_ack_seen", {63'd0, got}, 64'd1);
      if_req = 1'b0;
    end
    flush = 1'b0;
  endtask

  task automatic run_mem(input int n);
    for (int i = 0; i < n; i++) begin
      bit got;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      mem_req   = 1'b1;
      mem_we    = 1'($urandom_range(0, 1));
      mem_addr  = 32'h2000 | (32'($urandom_range(0, 255)) << 2);
      mem_wdata = $urandom;
      mem_sel   = 4'($urandom_range(1, 15));
      got = 0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(posedge clk); #1;
        if (mem_ack) got = 1;
      end
      check("mem_ack_seen", {63'd0, got}, 64'd1);
      mem_req = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit got;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_bus",   {59'd0, bus_req, bus_we, bus_sel}, 64'd0);
    check("rst_addr",  bus_addr,  64'd0);
    check("rst_acks",  {61'd0, if_ack, mem_ack, bus_err}, 64'd0);
    #2 rst = 1'b1;
    mon_en = 1'b1;

    fork
      run_fetch(80);
      run_mem(60);
    join

    for (int c = 0; c < 50 && (exp_q.size() != 0 || bus_req); c++) begin
      @(posedge clk); #1;
    end
    check("drain_idle", {63'd0, bus_req}, 64'd0);

    // Reset while a data access is stuck on the bus.
    no_ack_mode = 1'b1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000; mem_sel = 4'hF;
    repeat (2) begin @(posedge clk); #1; end
    check("busy_before_rst", {63'd0, bus_req}, 64'd1);
    mon_en  = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h40;
    #2 rst = 1'b0;
    mem_req = 1'b0;
    #1;
    check("async_rst_bus",   {59'd0, bus_req, bus_we, bus_sel}, 64'd0);
    check("async_rst_addr",  bus_addr,  64'd0);
    check("async_rst_wdata", bus_wdata, 64'd0);
    check("async_rst_acks",  {61'd0, if_ack, mem_ack, bus_err}, 64'd0);
    check("async_rst_rdata", {if_rdata, mem_rdata}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    mon_en = 1'b1;
    no_ack_mode = 1'b0;

    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      @(posedge clk); #1;
      if (if_ack) got = 1;
    end
    check("post_rst_fetch", {63'd0, got}, 64'd1);
    if_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation bound exceeded at t=%0t", $time);
    $fatal(1, "simulation bound exceeded");
  end

endmodule : tb_mem_bus_arbiter
